// File: rtl/mm_conduit_bridge.sv
// Avalon-MM slave: N_OUT RW registers on a conduit, synchronised inputs with W1C edge capture and masked irq.
// Read latency 1 cycle, writes take effect on the strobe edge; no backpressure (always ready, no waitrequest).
module mm_conduit_bridge #(
    parameter int N_OUT       = 2,
    parameter int IN_W        = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  csi_clk,
    input  logic                  rsi_reset_n,
    input  logic [3:0]            avs_s0_address,
    input  logic                  avs_s0_write,
    input  logic [31:0]           avs_s0_writedata,
    input  logic [3:0]            avs_s0_byteenable,
    input  logic                  avs_s0_read,
    output logic [31:0]           avs_s0_readdata,
    input  logic [IN_W-1:0]       coe_c1_in_sig,
    output logic [32*N_OUT-1:0]   coe_c0_conduit,
    output logic                  ins_irq_irq
);

    localparam logic [3:0] A_IN   = 4'(N_OUT);
    localparam logic [3:0] A_EDGE = 4'(N_OUT + 1);
    localparam logic [3:0] A_MASK = 4'(N_OUT + 2);
    localparam logic [3:0] A_RISE = 4'(N_OUT + 3);
    localparam logic [3:0] A_FALL = 4'(N_OUT + 4);

    localparam int              CW       = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0]   ARM_DONE = CW'(SYNC_STAGES + 1);

    logic [31:0]     out_q [N_OUT];
    logic [IN_W-1:0] sync_q [SYNC_STAGES];
    logic [IN_W-1:0] prev_q;
    logic [IN_W-1:0] edge_q;
    logic [IN_W-1:0] mask_q;
    logic [IN_W-1:0] rise_en_q;
    logic [IN_W-1:0] fall_en_q;
    logic [CW-1:0]   arm_q;

    logic [31:0]     be_mask;
    logic [IN_W-1:0] syn;
    logic [IN_W-1:0] set_bits;
    logic [IN_W-1:0] clr_bits;
    logic [IN_W-1:0] edge_d;
    logic [31:0]     rd_mux;
    logic            wr_edge;
    logic            wr_mask;
    logic            wr_rise;
    logic            wr_fall;

    function automatic logic [IN_W-1:0] merge_narrow(input logic [IN_W-1:0] cur,
                                                     input logic [31:0]     wd,
                                                     input logic [31:0]     bm);
        return (cur & ~bm[IN_W-1:0]) | (wd[IN_W-1:0] & bm[IN_W-1:0]);
    endfunction

    function automatic logic [31:0] zext(input logic [IN_W-1:0] v);
        logic [31:0] r;
        r          = '0;
        r[IN_W-1:0] = v;
        return r;
    endfunction

    assign be_mask = {{8{avs_s0_byteenable[3]}}, {8{avs_s0_byteenable[2]}},
                      {8{avs_s0_byteenable[1]}}, {8{avs_s0_byteenable[0]}}};

    assign syn     = sync_q[SYNC_STAGES-1];
    assign wr_edge = avs_s0_write && (avs_s0_address == A_EDGE);
    assign wr_mask = avs_s0_write && (avs_s0_address == A_MASK);
    assign wr_rise = avs_s0_write && (avs_s0_address == A_RISE);
    assign wr_fall = avs_s0_write && (avs_s0_address == A_FALL);

    // Capture held off until the sync chain and prev hold real post-reset samples.
    assign set_bits = (arm_q == ARM_DONE)
                    ? ((syn & ~prev_q & rise_en_q) | (~syn & prev_q & fall_en_q))
                    : '0;
    assign clr_bits = wr_edge ? (avs_s0_writedata[IN_W-1:0] & be_mask[IN_W-1:0]) : '0;
    assign edge_d   = (edge_q & ~clr_bits) | set_bits;

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (avs_s0_address == 4'(k)) begin
                rd_mux = out_q[k];
            end
        end
        if (avs_s0_address == A_IN) begin
            rd_mux = zext(syn);
        end else if (avs_s0_address == A_EDGE) begin
            rd_mux = zext(edge_q);
        end else if (avs_s0_address == A_MASK) begin
            rd_mux = zext(mask_q);
        end else if (avs_s0_address == A_RISE) begin
            rd_mux = zext(rise_en_q);
        end else if (avs_s0_address == A_FALL) begin
            rd_mux = zext(fall_en_q);
        end
    end

    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n) begin
            for (int k = 0; k < N_OUT; k++) begin
                out_q[k] <= '0;
            end
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q          <= '0;
            edge_q          <= '0;
            mask_q          <= '0;
            rise_en_q       <= '0;
            fall_en_q       <= '0;
            arm_q           <= '0;
            avs_s0_readdata <= '0;
            coe_c0_conduit  <= '0;
            ins_irq_irq     <= 1'b0;
        end else begin
            sync_q[0] <= coe_c1_in_sig;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= syn;

            if (arm_q != ARM_DONE) begin
                arm_q <= arm_q + 1'b1;
            end

            edge_q      <= edge_d;
            ins_irq_irq <= |(edge_q & mask_q);

            if (wr_mask) mask_q    <= merge_narrow(mask_q,    avs_s0_writedata, be_mask);
            if (wr_rise) rise_en_q <= merge_narrow(rise_en_q, avs_s0_writedata, be_mask);
            if (wr_fall) fall_en_q <= merge_narrow(fall_en_q, avs_s0_writedata, be_mask);

            // Conduit lags OUT by one cycle so fabric sees a clean registered copy.
            for (int k = 0; k < N_OUT; k++) begin
                if (avs_s0_write && (avs_s0_address == 4'(k))) begin
                    out_q[k] <= (out_q[k] & ~be_mask) | (avs_s0_writedata & be_mask);
                end
                coe_c0_conduit[32*k +: 32] <= out_q[k];
            end

            avs_s0_readdata <= avs_s0_read ? rd_mux : '0;
        end
    end

endmodule

// File: doc/mm_conduit_bridge.md
Name: mm_conduit_bridge

Overview:
- Parametrised Avalon-MM slave bridging the HPS/Nios bus to fabric logic.
- Exposes N_OUT writable 32-bit registers driven onto a conduit.
- Samples IN_W asynchronous fabric inputs through a synchroniser and captures rising/falling edges into sticky, write-1-to-clear status bits.
- Edge status feeds a maskable level interrupt.

Parameters:
- N_OUT, 2, number of 32-bit output registers (1..8).
- IN_W, 3, input signal width (1..32).
- SYNC_STAGES, 2, synchroniser depth (2..4).

Ports:
- csi_clk  in  1  single clock.
- rsi_reset_n  in  1  synchronous active-low reset.
- avs_s0_address  in  4  word address.
- avs_s0_write  in  1  write strobe.
- avs_s0_writedata  in  32  write data.
- avs_s0_byteenable  in  4  byte lanes for writes.
- avs_s0_read  in  1  read strobe.
- avs_s0_readdata  out  32  registered read data.
- coe_c1_in_sig  in  IN_W  asynchronous fabric inputs.
- coe_c0_conduit  out  32*N_OUT  output registers; register k occupies bits [32k+31:32k].
- ins_irq_irq  out  1  interrupt, active-high level.

Behaviour:
- Reset:
  - Sampled only on the csi_clk rising edge while rsi_reset_n=0.
  - Clears all output registers, coe_c0_conduit, avs_s0_readdata, sync chain, edge history, EDGE, MASK, RISE_EN, FALL_EN, ins_irq_irq and the arm counter.
  - Reset asserted mid-transaction aborts it; no write takes effect that cycle.
- Register map (word address):
  - 0..N_OUT-1: OUT[k], RW.
  - N_OUT: IN, RO, synchronised input value, zero-extended.
  - N_OUT+1: EDGE, W1C.
  - N_OUT+2: MASK, RW.
  - N_OUT+3: RISE_EN, RW.
  - N_OUT+4: FALL_EN, RW.
  - Other addresses: reads return 0, writes ignored.
  - For IN, EDGE, MASK, RISE_EN and FALL_EN, bits at and above IN_W are 0 on read; writes to those bits are ignored.
- Writes:
  - Take effect at the clock edge where avs_s0_write=1.
  - Only bytes with byteenable=1 are updated. byteenable=0000 means no change.
  - For EDGE, a 1 in an enabled byte clears the bit.
- Conduit:
  - coe_c0_conduit is re-registered from OUT, so it changes 1 cycle after the register updates (2 edges after the write strobe).
- Reads:
  - Fixed latency 1: avs_s0_readdata is valid on the edge after avs_s0_read=1.
  - avs_s0_readdata is 0 in any cycle following read=0.
  - A read and a write to the same address in the same cycle returns the pre-write value.
- Synchroniser:
  - coe_c1_in_sig passes through SYNC_STAGES flops to give syn.
  - prev is syn delayed by one cycle.
  - rise = syn & ~prev & RISE_EN; fall = ~syn & prev & FALL_EN.
  - EDGE bit i is set on the next edge when rise[i] | fall[i] holds.
- Arm counter:
  - After reset, edge capture is suppressed for SYNC_STAGES+1 cycles (counter 0..SYNC_STAGES+1, saturating).
  - This prevents spurious edges from inputs that are already high. IN reads remain live during this window.
- Simultaneous set and clear: if an edge sets bit i in the same cycle a W1C clears it, set wins and the bit stays 1.
- Interrupt:
  - ins_irq_irq is registered: |(EDGE & MASK), updated every cycle.
  - It asserts 1 cycle after the relevant EDGE bit sets, and deasserts 1 cycle after the clear or mask write.
- Input latency: with SYNC_STAGES=2 and an input toggle just before edge t, the toggle appears as follows.
  - syn at edge t+1; IN read data follows one cycle later.
  - EDGE bit set at edge t+2.
  - ins_irq_irq high after edge t+3.
- Pulses shorter than one clock are not guaranteed to be captured.

Test Plan:
- Reset, then read all addresses 0..15 -> every readdata 0; conduit 0; irq 0.
- N_OUT=2: write 0xDEADBEEF to addr 1 with byteenable 0101, then read addr 1 -> 0x00AD00EF. Conduit bits [63:32] equal 0x00AD00EF exactly 2 edges after the write strobe.
- IN_W=3, RISE_EN=7, MASK=2: drive coe_c1_in_sig 000->010 -> EDGE=0x2 at edge t+2 and irq=1 at t+3. Write 0x2 to EDGE -> irq=0 two edges later.
- Hold coe_c1_in_sig=111 through reset release with RISE_EN=7 written immediately -> EDGE stays 0 while IN reads 0x7.
- FALL_EN=1, bit 0 falls in the same cycle a W1C of 0x1 hits EDGE -> EDGE bit0 remains 1.
- Read addr 2 (IN) on consecutive cycles, then idle -> readdata valid 1 cycle after each read, and 0 on the cycle after read deasserts.
